// File: rtl/sb_threshold_servo_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sb_threshold_servo_pkg                                       |
// | Description : Shared widths, channel indices and FSM encoding for the      |
// |               single-bin trigger threshold servo.                          |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
package sb_threshold_servo_pkg;

    localparam int SB_ADC_WIDTH = 12;
    localparam int SB_CNT_WIDTH = 16;
    localparam int NUM_CHAN     = 4;

    localparam logic [1:0] CH_ADC0 = 2'd0;
    localparam logic [1:0] CH_ADC1 = 2'd1;
    localparam logic [1:0] CH_ADC2 = 2'd2;
    localparam logic [1:0] CH_SSD  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COUNT  = 2'd1,
        ST_UPDATE = 2'd2
    } servo_state_e;

endpackage
`default_nettype wire

// File: rtl/sb_threshold_servo_rate_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sb_rate_counter                                              |
// | Description : Registered sample compare, rising-edge detect and saturating |
// |               crossing counter for one trigger channel.                    |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module sb_rate_counter #(
    parameter int ADC_WIDTH = 12,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic [ADC_WIDTH-1:0] sample_i,
    input  logic [ADC_WIDTH-1:0] thr_i,
    input  logic                 en_i,
    input  logic                 clr_i,
    output logic [CNT_WIDTH-1:0] count_o
);

    logic [ADC_WIDTH-1:0] sample_q;
    logic                 gt_q, gt_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;

    always_comb begin
        gt_d    = (sample_q > thr_i);
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && gt_d && !gt_q && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sample_q <= '0;
            gt_q     <= 1'b0;
            count_q  <= '0;
        end else begin
            sample_q <= sample_i;
            gt_q     <= gt_d;
            count_q  <= count_d;
        end
    end

    assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/sb_threshold_servo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sb_threshold_servo                                           |
// | Description : Windowed crossing-rate servo driving the four single-bin     |
// |               trigger thresholds toward a programmed rate band.            |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module sb_threshold_servo
    import sb_threshold_servo_pkg::*;
#(
    parameter int ADC_WIDTH    = SB_ADC_WIDTH,
    parameter int CNT_WIDTH    = SB_CNT_WIDTH,
    parameter int WIN_CYCLES   = 1200000,
    parameter int LOCK_WINDOWS = 4
) (
    input  logic                 CLK120,
    input  logic                 RESET_N,
    input  logic                 ENABLE,
    input  logic [3:0]           CHAN_MASK,
    input  logic [ADC_WIDTH-1:0] ADC0,
    input  logic [ADC_WIDTH-1:0] ADC1,
    input  logic [ADC_WIDTH-1:0] ADC2,
    input  logic [ADC_WIDTH-1:0] ADC_SSD,
    input  logic [ADC_WIDTH-1:0] THR_INIT,
    input  logic [ADC_WIDTH-1:0] THR_MIN,
    input  logic [ADC_WIDTH-1:0] THR_MAX,
    input  logic [7:0]           THR_STEP,
    input  logic [CNT_WIDTH-1:0] RATE_LO,
    input  logic [CNT_WIDTH-1:0] RATE_HI,
    output logic [ADC_WIDTH-1:0] TRIG_THR0,
    output logic [ADC_WIDTH-1:0] TRIG_THR1,
    output logic [ADC_WIDTH-1:0] TRIG_THR2,
    output logic [ADC_WIDTH-1:0] TRIG_SSD,
    output logic [3:0]           LOCKED,
    output logic                 BUSY,
    output logic                 WIN_DONE
);

    localparam int WIN_W  = $clog2(WIN_CYCLES);
    localparam int LOCK_W = $clog2(LOCK_WINDOWS + 1);
    localparam int XW     = ADC_WIDTH + 1;
    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WIN_CYCLES - 1);
    localparam logic [LOCK_W-1:0] LOCK_FULL = LOCK_W'(LOCK_WINDOWS);

    servo_state_e state_q, state_d;
    logic [1:0]                               idx_q, idx_d;
    logic [WIN_W-1:0]                         win_q, win_d;
    logic [NUM_CHAN-1:0][ADC_WIDTH-1:0]       thr_q, thr_d;
    logic [NUM_CHAN-1:0][LOCK_W-1:0]          lock_q, lock_d;
    logic [NUM_CHAN-1:0]                      locked_q, locked_d;

    logic [ADC_WIDTH-1:0] samples [NUM_CHAN];
    logic [CNT_WIDTH-1:0] counts  [NUM_CHAN];
    logic [NUM_CHAN-1:0]  cnt_en, cnt_clr;

    logic [ADC_WIDTH-1:0] sel_thr, step_up, step_dn;
    logic [CNT_WIDTH-1:0] sel_cnt;
    logic [XW-1:0]        sum_x, diff_x;
    logic [LOCK_W-1:0]    lock_inc;
    logic                 above, below, last_visit;

    assign samples[CH_ADC0] = ADC0;
    assign samples[CH_ADC1] = ADC1;
    assign samples[CH_ADC2] = ADC2;
    assign samples[CH_SSD]  = ADC_SSD;

    assign last_visit = (state_q == ST_UPDATE) && (idx_q == CH_SSD);

    for (genvar i = 0; i < NUM_CHAN; i++) begin : g_chan
        assign cnt_en[i]  = (state_q == ST_COUNT) && CHAN_MASK[i];
        assign cnt_clr[i] = !ENABLE || !CHAN_MASK[i] || (state_q == ST_IDLE) || last_visit;

        sb_rate_counter #(
            .ADC_WIDTH (ADC_WIDTH),
            .CNT_WIDTH (CNT_WIDTH)
        ) u_rate_counter (
            .clk_i    (CLK120),
            .rst_n_i  (RESET_N),
            .sample_i (samples[i]),
            .thr_i    (thr_q[i]),
            .en_i     (cnt_en[i]),
            .clr_i    (cnt_clr[i]),
            .count_o  (counts[i])
        );
    end

    always_ff @(posedge CLK120 or negedge RESET_N) begin
        if (!RESET_N) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (!ENABLE) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:   state_d = ST_COUNT;
                ST_COUNT:  if (win_q == WIN_LAST) state_d = ST_UPDATE;
                ST_UPDATE: if (idx_q == CH_SSD) state_d = ST_COUNT;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        BUSY     = (state_q != ST_IDLE);
        WIN_DONE = ENABLE && last_visit;
    end

    // Shared step/clamp path; one extra bit keeps the sum and difference from wrapping.
    always_comb begin
        sel_thr  = thr_q[idx_q];
        sel_cnt  = counts[idx_q];
        sum_x    = {1'b0, sel_thr} + XW'(THR_STEP);
        diff_x   = {1'b0, sel_thr} - XW'(THR_STEP);
        step_up  = (sum_x > {1'b0, THR_MAX}) ? THR_MAX : sum_x[ADC_WIDTH-1:0];
        step_dn  = (diff_x[ADC_WIDTH] || (diff_x < {1'b0, THR_MIN})) ? THR_MIN : diff_x[ADC_WIDTH-1:0];
        above    = (sel_cnt > RATE_HI);
        below    = (sel_cnt < RATE_LO);
        lock_inc = (lock_q[idx_q] == LOCK_FULL) ? LOCK_FULL : lock_q[idx_q] + 1'b1;
    end

    always_comb begin
        win_d    = win_q;
        idx_d    = idx_q;
        thr_d    = thr_q;
        lock_d   = lock_q;
        locked_d = locked_q;
        if (!ENABLE) begin
            win_d    = '0;
            idx_d    = '0;
            lock_d   = '0;
            locked_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    for (int i = 0; i < NUM_CHAN; i++) thr_d[i] = THR_INIT;
                    win_d    = '0;
                    idx_d    = '0;
                    lock_d   = '0;
                    locked_d = '0;
                end
                ST_COUNT: begin
                    idx_d = '0;
                    win_d = (win_q == WIN_LAST) ? '0 : win_q + 1'b1;
                end
                ST_UPDATE: begin
                    idx_d = idx_q + 2'd1;
                    win_d = '0;
                    if (!CHAN_MASK[idx_q]) begin
                        locked_d[idx_q] = 1'b1;
                    end else if (above) begin
                        thr_d[idx_q]    = step_up;
                        lock_d[idx_q]   = '0;
                        locked_d[idx_q] = 1'b0;
                    end else if (below) begin
                        thr_d[idx_q]    = step_dn;
                        lock_d[idx_q]   = '0;
                        locked_d[idx_q] = 1'b0;
                    end else begin
                        lock_d[idx_q]   = lock_inc;
                        locked_d[idx_q] = (lock_inc == LOCK_FULL);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK120 or negedge RESET_N) begin
        if (!RESET_N) begin
            win_q    <= '0;
            idx_q    <= '0;
            thr_q    <= '1;
            lock_q   <= '0;
            locked_q <= '0;
        end else begin
            win_q    <= win_d;
            idx_q    <= idx_d;
            thr_q    <= thr_d;
            lock_q   <= lock_d;
            locked_q <= locked_d;
        end
    end

    assign TRIG_THR0 = thr_q[CH_ADC0];
    assign TRIG_THR1 = thr_q[CH_ADC1];
    assign TRIG_THR2 = thr_q[CH_ADC2];
    assign TRIG_SSD  = thr_q[CH_SSD];
    assign LOCKED    = locked_q;

endmodule
`default_nettype wire

// File: tb/tb_sb_threshold_servo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_sb_threshold_servo                                        |
// | Description : Randomized windowed-pulse bench with a rate-band reference   |
// |               model for sb_threshold_servo.                                |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_sb_threshold_servo;

    localparam int AW     = 12;
    localparam int CW     = 5;
    localparam int WIN    = 100;
    localparam int LOCKW  = 4;
    localparam int CMAX   = (1 << CW) - 1;
    localparam int PERIOD = WIN + 4;
    localparam int SLOTS  = 40;

    logic          clk = 1'b0;
    logic          rst_n, en;
    logic [3:0]    mask;
    logic [AW-1:0] adc_v [4];
    logic [AW-1:0] thr_init, thr_min, thr_max;
    logic [7:0]    thr_step;
    logic [CW-1:0] rate_lo, rate_hi;
    logic [AW-1:0] trig [4];
    logic [3:0]    locked;
    logic          busy, win_done;

    int   n_vec = 0, n_bad = 0, cyc = 0, last_done = 0;
    bit   last_done_valid = 0;
    int   thr_m [4];
    int   lock_m [4];
    logic [3:0] locked_m;
    int   n_lo [4], n_hi [4];
    bit   amp_hi;

    sb_threshold_servo #(
        .ADC_WIDTH    (AW),
        .CNT_WIDTH    (CW),
        .WIN_CYCLES   (WIN),
        .LOCK_WINDOWS (LOCKW)
    ) dut (
        .CLK120    (clk),
        .RESET_N   (rst_n),
        .ENABLE    (en),
        .CHAN_MASK (mask),
        .ADC0      (adc_v[0]),
        .ADC1      (adc_v[1]),
        .ADC2      (adc_v[2]),
        .ADC_SSD   (adc_v[3]),
        .THR_INIT  (thr_init),
        .THR_MIN   (thr_min),
        .THR_MAX   (thr_max),
        .THR_STEP  (thr_step),
        .RATE_LO   (rate_lo),
        .RATE_HI   (rate_hi),
        .TRIG_THR0 (trig[0]),
        .TRIG_THR1 (trig[1]),
        .TRIG_THR2 (trig[2]),
        .TRIG_SSD  (trig[3]),
        .LOCKED    (locked),
        .BUSY      (busy),
        .WIN_DONE  (win_done)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic check_outputs(input string tag);
        for (int i = 0; i < 4; i++)
            check_val($sformatf("%s_thr%0d", tag, i), 32'(trig[i]), 32'(thr_m[i]));
        check_val({tag, "_locked"}, 32'(locked), 32'(locked_m));
    endtask

    // Rate-band rule applied to one channel after a window with xc crossings.
    function automatic void update_model(input int i, input int xc);
        int cnt;
        if (!mask[i]) begin
            locked_m[i] = 1'b1;
            return;
        end
        cnt = (xc > CMAX) ? CMAX : xc;
        if (cnt > int'(rate_hi)) begin
            thr_m[i]  = (thr_m[i] + int'(thr_step) > int'(thr_max)) ? int'(thr_max) : thr_m[i] + int'(thr_step);
            lock_m[i] = 0;
        end else if (cnt < int'(rate_lo)) begin
            thr_m[i]  = (thr_m[i] - int'(thr_step) < int'(thr_min)) ? int'(thr_min) : thr_m[i] - int'(thr_step);
            lock_m[i] = 0;
        end else begin
            lock_m[i] = (lock_m[i] < LOCKW) ? lock_m[i] + 1 : LOCKW;
        end
        locked_m[i] = (lock_m[i] == LOCKW);
    endfunction

    function automatic logic [AW-1:0] pick_amp(input int i);
        int r;
        if (amp_hi) return 12'd4094;
        r = $urandom_range(0, 3);
        if (r == 0) return AW'(thr_m[i]);
        if (r == 1) return AW'((thr_m[i] < 4095) ? thr_m[i] + 1 : 4095);
        return AW'($urandom_range(0, 4095));
    endfunction

    task automatic do_enable();
        en = 1'b0;
        tick();
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            thr_m[i]  = int'(thr_init);
            lock_m[i] = 0;
        end
        locked_m = 4'b0000;
        last_done_valid = 0;
        tick();
        check_outputs("enable");
        check_val("enable_busy", 32'(busy), 32'd1);
    endtask

    // Starts on the first COUNT cycle of a window; pulses sit well inside the window.
    task automatic run_window(input bit abort);
        int n [4];
        int xc [4];
        logic [AW-1:0] amp [4][SLOTS];
        int  t0;
        bit  seen;
        t0 = cyc;
        for (int i = 0; i < 4; i++) begin
            n[i]  = $urandom_range(n_lo[i], n_hi[i]);
            xc[i] = 0;
            for (int k = 0; k < SLOTS; k++) begin
                amp[i][k] = pick_amp(i);
                if (k < n[i] && int'(amp[i][k]) > thr_m[i]) xc[i]++;
            end
        end
        repeat (4) tick();
        for (int k = 0; k < SLOTS; k++) begin
            for (int i = 0; i < 4; i++) adc_v[i] = (k < n[i]) ? amp[i][k] : '0;
            tick();
            for (int i = 0; i < 4; i++) adc_v[i] = '0;
            tick();
        end
        if (abort) begin
            while (cyc < t0 + WIN + 1) tick();
            en = 1'b0;
            update_model(0, xc[0]);
            for (int i = 0; i < 4; i++) lock_m[i] = 0;
            locked_m = 4'b0000;
            last_done_valid = 0;
            tick();
            check_val("abort_busy", 32'(busy), 32'd0);
            check_val("abort_win_done", 32'(win_done), 32'd0);
            check_outputs("abort");
        end else begin
            seen = 0;
            for (int w = 0; w < 40 && !seen; w++) begin
                tick();
                if (win_done) seen = 1;
            end
            check_val("win_done_seen", 32'(seen), 32'd1);
            if (seen) begin
                if (last_done_valid) check_val("win_period", 32'(cyc - last_done), 32'(PERIOD));
                last_done       = cyc;
                last_done_valid = 1;
                for (int i = 0; i < 4; i++) update_model(i, xc[i]);
                tick();
                check_val("win_done_width", 32'(win_done), 32'd0);
                check_outputs("window");
            end
        end
    endtask

    task automatic set_n(input int lo, input int hi);
        for (int i = 0; i < 4; i++) begin
            n_lo[i] = lo;
            n_hi[i] = hi;
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n    = 1'b0;
        en       = 1'b0;
        mask     = 4'hF;
        for (int i = 0; i < 4; i++) adc_v[i] = '0;
        thr_init = 12'd100;
        thr_min  = 12'd20;
        thr_max  = 12'd3000;
        thr_step = 8'd10;
        rate_lo  = 5'd2;
        rate_hi  = 5'd5;
        amp_hi   = 1'b0;
        repeat (3) tick();
        for (int i = 0; i < 4; i++) check_val($sformatf("reset_thr%0d", i), 32'(trig[i]), 32'hFFF);
        check_val("reset_locked", 32'(locked), 32'd0);
        check_val("reset_busy", 32'(busy), 32'd0);
        check_val("reset_win_done", 32'(win_done), 32'd0);
        rst_n = 1'b1;
        tick();
        check_val("idle_thr0", 32'(trig[0]), 32'hFFF);

        // ADC0 ten pulses per window, other channels random
        do_enable();
        set_n(0, 8);
        n_lo[0] = 10; n_hi[0] = 10;
        repeat (5) run_window(1'b0);

        set_n(0, 12);
        repeat (8) run_window(1'b0);

        // upper clamp
        thr_max = 12'd115;
        amp_hi  = 1'b1;
        set_n(20, 20);
        do_enable();
        repeat (3) run_window(1'b0);

        // lower clamp
        thr_max = 12'd3000;
        thr_min = 12'd95;
        set_n(0, 0);
        do_enable();
        repeat (3) run_window(1'b0);

        // counter saturation: 40 crossings saturate at 31, above a band top of 30
        thr_min = 12'd20;
        rate_hi = 5'd30;
        set_n(0, 0);
        n_lo[0] = SLOTS; n_hi[0] = SLOTS;
        do_enable();
        repeat (2) run_window(1'b0);

        // lock after four in-band windows, then SSD drops out of band
        rate_hi = 5'd5;
        set_n(4, 4);
        do_enable();
        repeat (4) run_window(1'b0);
        check_val("lock_all", 32'(locked), 32'hF);
        n_lo[3] = 0; n_hi[3] = 0;
        run_window(1'b0);

        // masked channels hold and report locked
        mask   = 4'b0101;
        amp_hi = 1'b0;
        set_n(6, 12);
        do_enable();
        repeat (2) run_window(1'b0);

        // abandon an update pass on its second cycle
        mask   = 4'hF;
        amp_hi = 1'b1;
        set_n(10, 10);
        run_window(1'b0);
        run_window(1'b1);
        tick();
        check_val("abort_idle_win_done", 32'(win_done), 32'd0);

        // asynchronous reset in the middle of a window
        do_enable();
        repeat (30) tick();
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) check_val($sformatf("async_rst_thr%0d", i), 32'(trig[i]), 32'hFFF);
        check_val("async_rst_busy", 32'(busy), 32'd0);
        check_val("async_rst_locked", 32'(locked), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
